inst_word_assembler: RTL and testbench
======================================

# inst_word_assembler

Parametrised instruction-word register that collects an instruction from a narrow bus over several beats, holds it, and presents it as a whole word and as its instruction/absolute fields. It generalises the combinational word-to-opcode split in the definitions package: configurable bus width, word width, field boundary and beat order, with valid/ready handshakes on both sides. It sits between the fetch bus and the decode stage.

## Interface

Parameters:
- BUS_W, default 8: input beat width in bits.
- WORD_W, default 32: assembled word width. Must be an integer multiple of BUS_W; elaboration fails otherwise.
- OPC_W, default 16: width of the instruction field, taken from the MSBs of the word. Requires 1 ≤ OPC_W < WORD_W.
- MSB_FIRST, default 1:
  - 1: the first beat fills the top BUS_W bits of the word.
  - 0: the first beat fills the bottom BUS_W bits.

Derived: BEATS = WORD_W/BUS_W; CNT_W = max(1, $clog2(BEATS)).

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- flush, input, 1: synchronous discard of the partial word and the held word.
- in_valid, input, 1: in_data carries a beat.
- in_ready, output, 1: the block accepts a beat this cycle.
- in_data, input, BUS_W: beat data.
- out_valid, output, 1: out_word and its fields are valid.
- out_ready, input, 1: the consumer takes the word this cycle.
- out_word, output, WORD_W: the assembled word.
- out_instruction, output, OPC_W: out_word[WORD_W-1 -: OPC_W].
- out_absolute, output, WORD_W-OPC_W: out_word[WORD_W-OPC_W-1:0].
- beat_cnt, output, CNT_W: number of beats of the current word already accepted.

## Operation

- Two states:
  - COLLECT: a word is being assembled.
  - HOLD: a complete word is presented.
- in_ready is combinational: (COLLECT or (HOLD and out_ready)) and rst_n and not flush.
- A beat is accepted when in_valid and in_ready are both high.
- Beat k (k = beat_cnt, 0-based) is written to the assembly register:
  - MSB_FIRST=1: slice [WORD_W-1-k*BUS_W -: BUS_W].
  - MSB_FIRST=0: slice [k*BUS_W +: BUS_W].
- Accepting a beat with beat_cnt < BEATS-1 increments beat_cnt.
- Accepting a beat with beat_cnt == BEATS-1 (the last beat):
  - the completed word, including this beat, is copied to out_word;
  - out_valid is set, beat_cnt wraps to 0, and the state moves to HOLD.
- HOLD:
  - out_word and out_valid stay stable until out_ready is high.
  - If out_ready is high and no beat is accepted: out_valid clears and the state returns to COLLECT.
  - If out_ready is high and a beat is accepted in the same cycle: that beat starts the next word.
    - BEATS > 1: state becomes COLLECT with beat_cnt = 1.
    - BEATS == 1: out_word is reloaded directly and the state stays HOLD with out_valid = 1.
- Field outputs are pure slices of out_word; no separate registers.
- Assembly-register bits not yet written in the current word are don't-care. Every bit is overwritten before the word is presented.
- flush (rst_n high):
  - next cycle: state COLLECT, beat_cnt 0, out_valid 0;
  - any beat or out_ready seen in the flush cycle is ignored;
  - out_word keeps its old value.
- Reset (rst_n low at a rising edge): state COLLECT, beat_cnt 0, out_valid 0, out_word 0.
  - Reset mid-word discards the partial word.
  - Reset has priority over flush.

## Timing

- Reset values: out_valid 0, out_word 0 (hence out_instruction and out_absolute 0), beat_cnt 0, in_ready 0 while rst_n is low.
- Latency: out_valid rises on the edge that accepts the last beat. For BEATS=4 with beats on cycles 0-3, out_valid is high from cycle 4.
- Throughput: with out_ready tied high and in_valid continuous, the block sustains one word per BEATS cycles, with no bubble.
- out_valid must never drop without a handshake, except on flush or reset.
- Handshake dependencies:
  - in_ready depends combinationally on out_ready.
  - out_valid does not depend on in_valid.

## Test plan

- Default parameters, beats CA, FE, 00, FE on consecutive cycles, out_ready=1 → out_word 32'hCAFE00FE, out_instruction 16'hCAFE, out_absolute 16'h00FE. out_valid is high for exactly one cycle, on cycle 4.
- MSB_FIRST=0, beats FE, 00, FE, CA → same out_word 32'hCAFE00FE.
- Backpressure: out_ready=0 for 5 cycles after completion → out_word is stable and in_ready is 0. On out_ready=1 with the next beat 12 present, that beat is accepted in the same cycle and beat_cnt becomes 1.
- Back-to-back: words CAFE00FE and 12345678 streamed continuously with out_ready=1 → the two words appear 4 cycles apart, with no gaps or corruption.
- Flush after 2 beats, then beats DE, AD, BE, EF → out_word 32'hDEADBEEF and beat_cnt restarted at 0. The same outcome is required for rst_n low mid-word.
- BUS_W=32, WORD_W=32, OPC_W=8: continuous input with out_ready=1 → a one-cycle pipeline register. Word A5000001 gives out_instruction 8'hA5 and out_absolute 24'h000001.

Source files
------------

// File: rtl/inst_word_assembler_if.sv
// Handshake bus of the instruction-word assembler: narrow beat input on one side,
// assembled word and its instruction/absolute fields on the other.
interface inst_word_assembler_if #(
    parameter int unsigned BUS_W  = 8,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OPC_W  = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [BUS_W-1:0]          in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_W-1:0]         out_word;
    logic [OPC_W-1:0]          out_instruction;
    logic [WORD_W-OPC_W-1:0]   out_absolute;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_word, out_instruction, out_absolute
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_word, out_instruction, out_absolute
    );
endinterface

// File: rtl/inst_word_assembler.sv
// Collects an instruction word from BUS_W-wide beats, holds it until the consumer
// takes it, and presents it whole and split into instruction/absolute fields.
module inst_word_assembler #(
    parameter int unsigned BUS_W     = 8,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned OPC_W     = 16,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned BEATS    = WORD_W / BUS_W,
    localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    inst_word_assembler_if.slave  bus,
    output logic [CNT_W-1:0]      beat_cnt
);

    if ((WORD_W % BUS_W) != 0 || OPC_W < 1 || OPC_W >= WORD_W) begin : gen_param_err
        $error("inst_word_assembler: illegal BUS_W/WORD_W/OPC_W combination");
    end

    typedef enum logic {StCollect, StHold} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic [WORD_W-1:0]   asm_q;
    logic [WORD_W-1:0]   asm_d;
    logic [WORD_W-1:0]   word_q;
    logic                valid_q;
    logic                accept;
    logic                last_beat;

    assign bus.in_ready = ((state_q == StCollect) || bus.out_ready) && rst_n && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_beat    = (beat_cnt_q == CNT_W'(BEATS - 1));

    // Assembly register with the current beat merged in, so the last beat can be
    // copied to the output in the same edge that accepts it.
    always_comb begin
        asm_d = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt_q == CNT_W'(b)) begin
                if (MSB_FIRST) begin
                    asm_d[WORD_W-1-b*BUS_W -: BUS_W] = bus.in_data;
                end else begin
                    asm_d[b*BUS_W +: BUS_W] = bus.in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StCollect;
            beat_cnt_q <= '0;
            asm_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
        end else if (flush) begin
            state_q    <= StCollect;
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (state_q == StHold && bus.out_ready) begin
                state_q <= StCollect;
                valid_q <= 1'b0;
            end
            if (accept) begin
                asm_q <= asm_d;
                if (last_beat) begin
                    word_q     <= asm_d;
                    valid_q    <= 1'b1;
                    beat_cnt_q <= '0;
                    state_q    <= StHold;
                end else begin
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    state_q    <= StCollect;
                end
            end
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_word        = word_q;
    assign bus.out_instruction = word_q[WORD_W-1 -: OPC_W];
    assign bus.out_absolute    = word_q[WORD_W-OPC_W-1:0];
    assign beat_cnt            = beat_cnt_q;

endmodule

// File: tb/tb_inst_word_assembler.sv
// Self-checking bench: directed scenarios on three parameterisations plus a
// randomized run against a beat-queue reference model.
module tb_inst_word_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b, rst_n_c;
    logic flush_a, flush_b, flush_c;
    logic [1:0] cnt_a, cnt_b;
    logic [0:0] cnt_c;

    inst_word_assembler_if #(.BUS_W(8),  .WORD_W(32), .OPC_W(16)) if_a ();
    inst_word_assembler_if #(.BUS_W(8),  .WORD_W(32), .OPC_W(16)) if_b ();
    inst_word_assembler_if #(.BUS_W(32), .WORD_W(32), .OPC_W(8))  if_c ();

    inst_word_assembler #(.BUS_W(8), .WORD_W(32), .OPC_W(16), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .flush(flush_a), .bus(if_a), .beat_cnt(cnt_a)
    );
    inst_word_assembler #(.BUS_W(8), .WORD_W(32), .OPC_W(16), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .flush(flush_b), .bus(if_b), .beat_cnt(cnt_b)
    );
    inst_word_assembler #(.BUS_W(32), .WORD_W(32), .OPC_W(8), .MSB_FIRST(1'b1)) u_dut_c (
        .clk(clk), .rst_n(rst_n_c), .flush(flush_c), .bus(if_c), .beat_cnt(cnt_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_word_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic r);
        if_a.in_valid  = v;
        if_a.in_data   = d;
        if_a.out_ready = r;
        #2;
    endtask

    // Drives MSB-first beats of w on consecutive cycles, out_ready high.
    task automatic send_word_a(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, w[31-8*k -: 8], 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        if_a.in_valid = 1'b1; if_a.in_data = 8'h55; if_a.out_ready = 1'b1;
        if_b.in_valid = 1'b0; if_b.in_data = '0;    if_b.out_ready = 1'b1;
        if_c.in_valid = 1'b0; if_c.in_data = '0;    if_c.out_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (if_a.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", if_a.out_valid);
        end
        n_checks++;
        if (if_a.out_word !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_word: got %h expected 0", if_a.out_word);
        end
        n_checks++;
        if (cnt_a !== 2'd0) begin
            n_fail++; $display("FAIL reset_beat_cnt: got %0d expected 0", cnt_a);
        end
        n_checks++;
        if (if_a.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", if_a.in_ready);
        end
        n_checks++;
        if (if_a.out_instruction !== 16'h0 || if_a.out_absolute !== 16'h0) begin
            n_fail++; $display("FAIL reset_fields: got %h/%h expected 0/0",
                               if_a.out_instruction, if_a.out_absolute);
        end
        n_checks++;
        if (if_c.out_word !== 32'h0 || if_b.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_other: got %h/%b expected 0/0",
                               if_c.out_word, if_b.out_valid);
        end
        if_a.in_valid = 1'b0;
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] beats [4] = '{8'hCA, 8'hFE, 8'h00, 8'hFE};
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, beats[k], 1'b1);
            n_checks++;
            if (int'(cnt_a) !== k || if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL basic_collect[%0d]: got cnt=%0d valid=%b ready=%b expected cnt=%0d valid=0 ready=1",
                                   k, cnt_a, if_a.out_valid, if_a.in_ready, k);
            end
            tick();
        end
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_word !== 32'hCAFE00FE) begin
            n_fail++; $display("FAIL basic_word: got valid=%b word=%h expected 1/cafe00fe",
                               if_a.out_valid, if_a.out_word);
        end
        n_checks++;
        if (if_a.out_instruction !== 16'hCAFE || if_a.out_absolute !== 16'h00FE) begin
            n_fail++; $display("FAIL basic_fields: got %h/%h expected cafe/00fe",
                               if_a.out_instruction, if_a.out_absolute);
        end
        tick();
        n_checks++;
        if (if_a.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_one_cycle: got valid=%b expected 0", if_a.out_valid);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] beats [4] = '{8'hFE, 8'h00, 8'hFE, 8'hCA};
        for (int k = 0; k < 4; k++) begin
            if_b.in_valid = 1'b1; if_b.in_data = beats[k]; if_b.out_ready = 1'b1;
            tick();
        end
        if_b.in_valid = 1'b0;
        #2;
        n_checks++;
        if (if_b.out_valid !== 1'b1 || if_b.out_word !== 32'hCAFE00FE || cnt_b !== 2'd0) begin
            n_fail++; $display("FAIL lsb_word: got valid=%b word=%h cnt=%0d expected 1/cafe00fe/0",
                               if_b.out_valid, if_b.out_word, cnt_b);
        end
        tick();
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, 8'h10 + 8'(k), 1'b0);
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            drive_a(1'b1, 8'h12, 1'b0);
            n_checks++;
            if (if_a.in_ready !== 1'b0 || if_a.out_valid !== 1'b1 || if_a.out_word !== 32'h10111213) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got ready=%b valid=%b word=%h expected 0/1/10111213",
                                   c, if_a.in_ready, if_a.out_valid, if_a.out_word);
            end
            tick();
        end
        drive_a(1'b1, 8'h12, 1'b1);
        n_checks++;
        if (if_a.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 1", if_a.in_ready);
        end
        tick();
        #2;
        n_checks++;
        if (cnt_a !== 2'd1 || if_a.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_next_beat: got cnt=%0d valid=%b expected 1/0", cnt_a, if_a.out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 8'h34 + 8'(k) * 8'h22, 1'b1);
            tick();
        end
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_word !== 32'h12345678) begin
            n_fail++; $display("FAIL bp_second_word: got valid=%b word=%h expected 1/12345678",
                               if_a.out_valid, if_a.out_word);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2] = '{32'hCAFE00FE, 32'h12345678};
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive_a(1'b1, words[i/4][31-8*(i%4) -: 8], 1'b1);
            else       drive_a(1'b0, 8'h00, 1'b1);
            n_checks++;
            if (if_a.out_valid !== (i == 4 || i == 8)) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, if_a.out_valid, (i == 4 || i == 8));
            end
            if (i == 4 || i == 8) begin
                n_checks++;
                if (if_a.out_word !== words[i/4 - 1]) begin
                    n_fail++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, if_a.out_word, words[i/4 - 1]);
                end
            end
            tick();
        end
        last_word_a = words[1];
    endtask

    task automatic test_flush_and_reset();
        drive_a(1'b1, 8'h11, 1'b1); tick();
        drive_a(1'b1, 8'h22, 1'b1); tick();
        flush_a = 1'b1;
        drive_a(1'b1, 8'h99, 1'b1);
        n_checks++;
        if (if_a.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: got %b expected 0", if_a.in_ready);
        end
        tick();
        flush_a = 1'b0;
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (cnt_a !== 2'd0 || if_a.out_valid !== 1'b0 || if_a.out_word !== last_word_a) begin
            n_fail++; $display("FAIL flush_state: got cnt=%0d valid=%b word=%h expected 0/0/%h",
                               cnt_a, if_a.out_valid, if_a.out_word, last_word_a);
        end
        send_word_a(32'hDEADBEEF);
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_word !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL flush_word: got valid=%b word=%h expected 1/deadbeef",
                               if_a.out_valid, if_a.out_word);
        end
        tick();
        drive_a(1'b1, 8'h11, 1'b1); tick();
        drive_a(1'b1, 8'h22, 1'b1); tick();
        rst_n_a = 1'b0;
        flush_a = 1'b1;
        drive_a(1'b1, 8'h33, 1'b1);
        tick();
        rst_n_a = 1'b1;
        flush_a = 1'b0;
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (cnt_a !== 2'd0 || if_a.out_valid !== 1'b0 || if_a.out_word !== 32'h0) begin
            n_fail++; $display("FAIL midreset_state: got cnt=%0d valid=%b word=%h expected 0/0/0",
                               cnt_a, if_a.out_valid, if_a.out_word);
        end
        send_word_a(32'hDEADBEEF);
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_word !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL midreset_word: got valid=%b word=%h expected 1/deadbeef",
                               if_a.out_valid, if_a.out_word);
        end
        tick();
    endtask

    task automatic test_pipeline();
        logic [31:0] data [6];
        for (int i = 0; i < 6; i++) data[i] = (i == 2) ? 32'hA5000001 : $urandom;
        for (int i = 0; i <= 6; i++) begin
            if_c.in_valid  = (i < 6);
            if_c.in_data   = (i < 6) ? data[i] : 32'h0;
            if_c.out_ready = 1'b1;
            #2;
            n_checks++;
            if (if_c.in_ready !== 1'b1 || if_c.out_valid !== (i > 0) || cnt_c !== 1'b0) begin
                n_fail++; $display("FAIL pipe_ctrl[%0d]: got ready=%b valid=%b cnt=%0d expected 1/%b/0",
                                   i, if_c.in_ready, if_c.out_valid, cnt_c, (i > 0));
            end
            if (i > 0) begin
                n_checks++;
                if (if_c.out_word !== data[i-1]) begin
                    n_fail++; $display("FAIL pipe_word[%0d]: got %h expected %h", i, if_c.out_word, data[i-1]);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (if_c.out_instruction !== 8'hA5 || if_c.out_absolute !== 24'h000001) begin
                    n_fail++; $display("FAIL pipe_fields: got %h/%h expected a5/000001",
                                       if_c.out_instruction, if_c.out_absolute);
                end
            end
            tick();
        end
    endtask

    // Reference: accepted beats sit in a queue; four of them form the presented word.
    task automatic test_random();
        logic [7:0]  q [$];
        bit          has_w = 1'b0;
        logic [31:0] w = '0;
        flush_a = 1'b1;
        drive_a(1'b0, 8'h00, 1'b0);
        tick();
        flush_a = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic       v, r, f, exp_ready;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 31) == 0);
            d = 8'($urandom);
            flush_a = f;
            drive_a(v, d, r);
            exp_ready = (!has_w || r) && !f;
            n_checks++;
            if (if_a.in_ready !== exp_ready || if_a.out_valid !== has_w || int'(cnt_a) !== q.size()) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: got ready=%b valid=%b cnt=%0d expected %b/%b/%0d",
                                   c, if_a.in_ready, if_a.out_valid, cnt_a, exp_ready, has_w, q.size());
            end
            if (has_w) begin
                n_checks++;
                if (if_a.out_word !== w || if_a.out_instruction !== w[31:16] || if_a.out_absolute !== w[15:0]) begin
                    n_fail++; $display("FAIL rand_word[%0d]: got %h expected %h", c, if_a.out_word, w);
                end
            end
            if (f) begin
                q.delete();
                has_w = 1'b0;
            end else begin
                if (has_w && r) has_w = 1'b0;
                if (v && exp_ready) begin
                    q.push_back(d);
                    if (q.size() == 4) begin
                        w = {q[0], q[1], q[2], q[3]};
                        has_w = 1'b1;
                        q.delete();
                    end
                end
            end
            tick();
        end
        flush_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lsb_first();
        test_backpressure();
        test_back_to_back();
        test_flush_and_reset();
        test_pipeline();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
